// File: rtl/glcd_frame_refresh.sv
// ---------------------------------------------------------------------------
// glcd_frame_refresh
//
// Refresh engine for a KS0108-class multi-chip graphic LCD. After power-up
// (panel reset pulse, settle wait, DISPLAY ON to every chip) it streams a
// page/column framebuffer to the panel, one frame per accepted enable.
// Every bus write is SETUP / E-HIGH / HOLD, each CLK_DIV clocks long. The
// chip selects, RS and the data bus are only changed on entry to SETUP.
//
// Optional feature (compile-time macro GLCD_DIRTY_PAGE_EN):
//   adds page_dirty / page_clr. Pages whose dirty bit is clear are skipped
//   entirely, and a refreshed page pulses its page_clr bit when finished.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   en                start a frame (sampled only while idle)
//   fb_rd_en          framebuffer read strobe, data expected one clock later
//   fb_page, fb_col   framebuffer read address (page, global column)
//   fb_data           framebuffer read data
//   lcd_reset_n       panel reset (active-low)
//   lcd_cs            one active-high chip select per controller chip
//   lcd_rs            0 = command, 1 = display data
//   lcd_rw            tied to write
//   lcd_e             enable strobe
//   lcd_data          panel data bus
//   busy              a frame is in progress
//   frame_done        one-clock pulse after the last write of a frame
//   page_dirty        (GLCD_DIRTY_PAGE_EN) pages that need refreshing
//   page_clr          (GLCD_DIRTY_PAGE_EN) one-clock "page refreshed" pulse
// ---------------------------------------------------------------------------
module glcd_frame_refresh #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_CHIPS  = 2,
    parameter int CHIP_COLS  = 64,
    parameter int NUM_PAGES  = 8,
    parameter int RST_CYCLES = 256,
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
    localparam int GCOL_W = (NUM_CHIPS * CHIP_COLS > 1) ? $clog2(NUM_CHIPS * CHIP_COLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 fb_rd_en,
    output logic [PAGE_W-1:0]    fb_page,
    output logic [GCOL_W-1:0]    fb_col,
    input  logic [7:0]           fb_data,
    output logic                 lcd_reset_n,
    output logic [NUM_CHIPS-1:0] lcd_cs,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_data,
    output logic                 busy,
    output logic                 frame_done
`ifdef GLCD_DIRTY_PAGE_EN
    ,
    input  logic [NUM_PAGES-1:0] page_dirty,
    output logic [NUM_PAGES-1:0] page_clr
`endif
);

    localparam int CHIP_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam int COL_W  = (CHIP_COLS > 1) ? $clog2(CHIP_COLS) : 1;
    localparam int BUS_W  = $clog2(3 * CLK_DIV + 1);
    localparam int TMR_W  = $clog2(RST_CYCLES + 1);

    localparam logic [7:0] CMD_DISP_ON  = 8'h3F;
    localparam logic [7:0] CMD_SET_PAGE = 8'hB8;
    localparam logic [7:0] CMD_SET_COL0 = 8'h40;

    typedef enum logic [3:0] {
        PWR_RST,
        PWR_WAIT,
        DISP_ON,
        IDLE,
        SET_PAGE,
        SET_COL,
        FETCH,
        WRITE,
        NEXT
    } state_t;

    state_t              state;
    logic [TMR_W-1:0]    tmr;
    logic [BUS_W-1:0]    bus_cnt;
    logic [PAGE_W-1:0]   page;
    logic [CHIP_W-1:0]   chip;
    logic [COL_W-1:0]    col;
    logic                fetch_ph;
    // Set when a frame starts with no page to refresh; the frame then
    // runs SET_PAGE -> NEXT without touching the bus.
    logic                skip;

    logic [NUM_PAGES-1:0] dirty_mask;
    logic                 bus_state;
    logic                 bus_done;
    logic [BUS_W-1:0]     bus_nxt;
    logic [PAGE_W:0]      first_pg;
    logic [PAGE_W:0]      next_pg;
    logic                 last_chip;
    logic                 last_col;

`ifdef GLCD_DIRTY_PAGE_EN
    assign dirty_mask = page_dirty;
`else
    assign dirty_mask = '1;
`endif

    assign lcd_rw = 1'b0;

    // Lowest page at or above 'from' whose mask bit is set.
    // Result is {found, page}.
    function automatic logic [PAGE_W:0] find_page(input logic [NUM_PAGES-1:0] mask,
                                                  input int from);
        logic [PAGE_W:0] r;
        r = '0;
        for (int i = NUM_PAGES - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                r = {1'b1, PAGE_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_CHIPS-1:0] cs_of(input logic [CHIP_W-1:0] c);
        return NUM_CHIPS'(1) << c;
    endfunction

    function automatic logic [GCOL_W-1:0] gcol(input logic [CHIP_W-1:0] c,
                                               input logic [COL_W-1:0] k);
        return GCOL_W'(c) * GCOL_W'(CHIP_COLS) + GCOL_W'(k);
    endfunction

    assign bus_state = ((state == DISP_ON) || (state == SET_COL) || (state == WRITE) ||
                        ((state == SET_PAGE) && !skip));
    assign bus_nxt   = bus_cnt + 1'b1;
    assign bus_done  = (bus_cnt == BUS_W'(3 * CLK_DIV - 1));
    assign first_pg  = find_page(dirty_mask, 0);
    assign next_pg   = find_page(dirty_mask, int'(page) + 1);
    assign last_chip = (chip == CHIP_W'(NUM_CHIPS - 1));
    assign last_col  = (col == COL_W'(CHIP_COLS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PWR_RST;
            tmr         <= '0;
            bus_cnt     <= '0;
            page        <= '0;
            chip        <= '0;
            col         <= '0;
            fetch_ph    <= 1'b0;
            skip        <= 1'b0;
            fb_rd_en    <= 1'b0;
            fb_page     <= '0;
            fb_col      <= '0;
            lcd_reset_n <= 1'b0;
            lcd_cs      <= '0;
            lcd_rs      <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef GLCD_DIRTY_PAGE_EN
            page_clr    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef GLCD_DIRTY_PAGE_EN
            page_clr   <= '0;
`endif
            // Shared bus-phase sequencer: count 0..3*CLK_DIV-1 inside any
            // write state, E high for counts CLK_DIV..2*CLK_DIV-1. States
            // entering a write restart the count by loading bus_cnt <= 0.
            if (bus_state) begin
                if (!bus_done) begin
                    bus_cnt <= bus_nxt;
                end
                if (bus_nxt == BUS_W'(CLK_DIV)) begin
                    lcd_e <= 1'b1;
                end else if (bus_nxt == BUS_W'(2 * CLK_DIV)) begin
                    lcd_e <= 1'b0;
                end
            end

            case (state)
                PWR_RST: begin
                    if (tmr == TMR_W'(RST_CYCLES - 1)) begin
                        tmr         <= '0;
                        lcd_reset_n <= 1'b1;
                        state       <= PWR_WAIT;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                PWR_WAIT: begin
                    if (tmr == TMR_W'(RST_CYCLES - 1)) begin
                        tmr      <= '0;
                        bus_cnt  <= '0;
                        lcd_cs   <= '1;
                        lcd_rs   <= 1'b0;
                        lcd_data <= CMD_DISP_ON;
                        state    <= DISP_ON;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                DISP_ON: begin
                    if (bus_done) begin
                        lcd_cs <= '0;
                        state  <= IDLE;
                    end
                end

                IDLE: begin
                    if (en) begin
                        busy  <= 1'b1;
                        chip  <= '0;
                        col   <= '0;
                        state <= SET_PAGE;
                        if (first_pg[PAGE_W]) begin
                            page     <= first_pg[PAGE_W-1:0];
                            bus_cnt  <= '0;
                            lcd_cs   <= cs_of('0);
                            lcd_rs   <= 1'b0;
                            lcd_data <= CMD_SET_PAGE | 8'(first_pg[PAGE_W-1:0]);
                        end else begin
                            page <= '0;
                            skip <= 1'b1;
                        end
                    end
                end

                SET_PAGE: begin
                    if (skip) begin
                        state <= NEXT;
                    end else if (bus_done) begin
                        bus_cnt  <= '0;
                        lcd_data <= CMD_SET_COL0;
                        state    <= SET_COL;
                    end
                end

                SET_COL: begin
                    if (bus_done) begin
                        col      <= '0;
                        fetch_ph <= 1'b0;
                        fb_rd_en <= 1'b1;
                        fb_page  <= page;
                        fb_col   <= gcol(chip, '0);
                        state    <= FETCH;
                    end
                end

                // Read request is one clock, the byte is captured the next.
                FETCH: begin
                    if (!fetch_ph) begin
                        fb_rd_en <= 1'b0;
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        bus_cnt  <= '0;
                        lcd_rs   <= 1'b1;
                        lcd_data <= fb_data;
                        state    <= WRITE;
                    end
                end

                // The panel auto-increments its column, so only the last
                // column of a chip needs the NEXT bookkeeping state.
                WRITE: begin
                    if (bus_done) begin
                        if (last_col) begin
                            col   <= '0;
                            state <= NEXT;
                        end else begin
                            col      <= col + 1'b1;
                            fb_rd_en <= 1'b1;
                            fb_col   <= gcol(chip, col + 1'b1);
                            state    <= FETCH;
                        end
                    end
                end

                NEXT: begin
                    if (skip) begin
                        skip       <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (!last_chip) begin
                        chip     <= chip + 1'b1;
                        bus_cnt  <= '0;
                        lcd_cs   <= cs_of(chip + 1'b1);
                        lcd_rs   <= 1'b0;
                        lcd_data <= CMD_SET_PAGE | 8'(page);
                        state    <= SET_PAGE;
                    end else begin
                        chip <= '0;
`ifdef GLCD_DIRTY_PAGE_EN
                        page_clr <= NUM_PAGES'(1) << page;
`endif
                        if (next_pg[PAGE_W]) begin
                            page     <= next_pg[PAGE_W-1:0];
                            bus_cnt  <= '0;
                            lcd_cs   <= cs_of('0);
                            lcd_rs   <= 1'b0;
                            lcd_data <= CMD_SET_PAGE | 8'(next_pg[PAGE_W-1:0]);
                            state    <= SET_PAGE;
                        end else begin
                            page       <= '0;
                            lcd_cs     <= '0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end

                default: state <= PWR_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_glcd_frame_refresh.sv
// Bench for glcd_frame_refresh with CLK_DIV=2, 2 chips x 64 columns,
// 8 pages, 16-cycle power-up reset.
module tb_glcd_frame_refresh;

    localparam int CLK_DIV    = 2;
    localparam int NUM_CHIPS  = 2;
    localparam int CHIP_COLS  = 64;
    localparam int NUM_PAGES  = 8;
    localparam int RST_CYCLES = 16;
    localparam int PER_CP     = 2 + CHIP_COLS;   // writes per chip-page

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] fb_data = 8'h00;
    logic       fb_rd_en;
    logic [2:0] fb_page;
    logic [6:0] fb_col;
    logic       lcd_reset_n;
    logic [1:0] lcd_cs;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic       frame_done;
`ifdef GLCD_DIRTY_PAGE_EN
    logic [7:0] page_dirty = 8'hFF;
    logic [7:0] page_clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    glcd_frame_refresh #(
        .CLK_DIV(CLK_DIV), .NUM_CHIPS(NUM_CHIPS), .CHIP_COLS(CHIP_COLS),
        .NUM_PAGES(NUM_PAGES), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .fb_rd_en(fb_rd_en), .fb_page(fb_page), .fb_col(fb_col), .fb_data(fb_data),
        .lcd_reset_n(lcd_reset_n), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy), .frame_done(frame_done)
`ifdef GLCD_DIRTY_PAGE_EN
        , .page_dirty(page_dirty), .page_clr(page_clr)
`endif
    );

    always #5 clk = ~clk;

    // Framebuffer model: byte = low bits of the global column, one clk latency.
    always @(posedge clk) begin
        if (fb_rd_en) fb_data <= 8'(fb_col);
    end

    // Bus monitor: logs every write at the E rising edge and checks strobe
    // width and setup/hold stability of cs/rs/data.
    logic [10:0] wr_q[$];
    logic [7:0]  clr_q[$];
    logic [10:0] bus_prev = '0;
    logic [10:0] held = '0;
    logic        prev_e = 1'b0;
    int          e_len = 0;
    int          stable = 0;
    int          post_cnt = 0;
    int          timing_err = 0;
    int          fd_cnt = 0;
    wire  [10:0] cur = {lcd_cs, lcd_rs, lcd_data};

    always @(negedge clk) begin
        if (reset) begin
            prev_e   <= 1'b0;
            e_len    <= 0;
            stable   <= 0;
            post_cnt <= 0;
            bus_prev <= cur;
        end else begin
            bus_prev <= cur;
            stable   <= (cur == bus_prev) ? stable + 1 : 0;
            prev_e   <= lcd_e;
            e_len    <= lcd_e ? e_len + 1 : 0;
            if (lcd_e && !prev_e) begin
                wr_q.push_back(cur);
                held <= cur;
                if (cur != bus_prev || stable < CLK_DIV - 1) timing_err <= timing_err + 1;
            end else if (lcd_e && prev_e) begin
                if (cur != held) timing_err <= timing_err + 1;
            end else if (!lcd_e && prev_e) begin
                if (e_len != CLK_DIV || cur != held) timing_err <= timing_err + 1;
                post_cnt <= CLK_DIV - 1;
            end else if (post_cnt != 0) begin
                if (cur != held) timing_err <= timing_err + 1;
                post_cnt <= post_cnt - 1;
            end
            if (frame_done) fd_cnt <= fd_cnt + 1;
`ifdef GLCD_DIRTY_PAGE_EN
            if (page_clr != 8'h00) clr_q.push_back(page_clr);
`endif
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({lcd_cs, lcd_rs, lcd_rw, lcd_e, lcd_data} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_pins: got %h required 0", {lcd_cs, lcd_rs, lcd_rw, lcd_e, lcd_data});
        end
        n_cmp++;
        if ({fb_rd_en, busy, frame_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 000", {fb_rd_en, busy, frame_done});
        end
        n_cmp++;
        if (lcd_reset_n !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lcd_reset_n: got %b required 0", lcd_reset_n);
        end
    endtask

    // Releases reset and follows the power-up sequence to DISPLAY ON.
    task automatic test_power_up();
        int low;
        int dly;
        @(negedge clk);
        reset = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (lcd_reset_n === 1'b1) break;
            low++;
            @(negedge clk);
        end
        n_cmp++;
        if (low !== RST_CYCLES) begin
            n_bad++;
            $display("FAIL pwr_reset_low: got %0d clks required %0d", low, RST_CYCLES);
        end
        dly = 0;
        while (lcd_e !== 1'b1 && dly < 100) begin
            @(negedge clk);
            dly++;
        end
        n_cmp++;
        if (dly !== RST_CYCLES + CLK_DIV) begin
            n_bad++;
            $display("FAIL pwr_e_delay: got %0d clks required %0d", dly, RST_CYCLES + CLK_DIV);
        end
        n_cmp++;
        if ({lcd_cs, lcd_rs, lcd_data} !== {2'b11, 1'b0, 8'h3F}) begin
            n_bad++;
            $display("FAIL pwr_disp_on: got cs=%b rs=%b data=%h required cs=11 rs=0 data=3f",
                     lcd_cs, lcd_rs, lcd_data);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pwr_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_full_frame();
        int base_w;
        int base_fd;
        int base_te;
        int n;
        int errs;
        int idx;
        logic [10:0] exp_v;
        logic [10:0] got_v;
        base_w  = wr_q.size();
        base_fd = fd_cnt;
        base_te = timing_err;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_busy_start: got %b required 1", busy);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_timeout: frame_done=%b after %0d clks required 1", frame_done, n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_busy_end: got %b required 0 with frame_done", busy);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || fd_cnt - base_fd !== 1) begin
            n_bad++;
            $display("FAIL frame_single: busy=%b frame_done count=%0d required busy=0 count=1",
                     busy, fd_cnt - base_fd);
        end
        n_cmp++;
        if (wr_q.size() - base_w !== 1056) begin
            n_bad++;
            $display("FAIL frame_pulses: got %0d required 1056", wr_q.size() - base_w);
        end
        n_cmp++;
        if (timing_err - base_te !== 0) begin
            n_bad++;
            $display("FAIL frame_timing: got %0d violations required 0", timing_err - base_te);
        end
        // Every write of the frame, in page / chip / column order.
        errs = 0;
        if (wr_q.size() - base_w >= 1056) begin
            for (int p = 0; p < NUM_PAGES; p++) begin
                for (int c = 0; c < NUM_CHIPS; c++) begin
                    for (int k = 0; k < PER_CP; k++) begin
                        idx = base_w + (p * NUM_CHIPS + c) * PER_CP + k;
                        if (k == 0)      exp_v = {2'(1 << c), 1'b0, 8'(8'hB8 + p)};
                        else if (k == 1) exp_v = {2'(1 << c), 1'b0, 8'h40};
                        else             exp_v = {2'(1 << c), 1'b1, 8'(c * 64 + k - 2)};
                        got_v = wr_q[idx];
                        if (got_v !== exp_v) begin
                            if (errs == 0)
                                $display("FAIL frame_content: write %0d got %h required %h",
                                         idx - base_w, got_v, exp_v);
                            errs++;
                        end
                    end
                end
            end
        end else begin
            errs = 1;
        end
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL frame_content_total: got %0d bad writes required 0", errs);
        end
        // Page 3, chip 1 spot checks.
        idx = base_w + 7 * PER_CP;
        if (wr_q.size() - base_w >= 1056) begin
            n_cmp++;
            if (wr_q[idx] !== {2'b10, 1'b0, 8'hBB} || wr_q[idx + 1] !== {2'b10, 1'b0, 8'h40}) begin
                n_bad++;
                $display("FAIL p3c1_cmds: got %h %h required 2bb 240", wr_q[idx], wr_q[idx + 1]);
            end
            n_cmp++;
            if (wr_q[idx + 2] !== {2'b10, 1'b1, 8'd64} || wr_q[idx + 65] !== {2'b10, 1'b1, 8'd127}) begin
                n_bad++;
                $display("FAIL p3c1_data: got %h %h required 540 57f", wr_q[idx + 2], wr_q[idx + 65]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base_fd;
        int n;
        base_fd = fd_cnt;
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_timeout1: frame_done=%b required 1", frame_done);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart: busy=%b required 1", busy);
        end
        repeat (100) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_finish: frame_done=%b busy=%b required 1 0", frame_done, busy);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || fd_cnt - base_fd !== 2) begin
            n_bad++;
            $display("FAIL b2b_stop: busy=%b frames=%0d required 0 2", busy, fd_cnt - base_fd);
        end
    endtask

`ifdef GLCD_DIRTY_PAGE_EN
    task automatic test_dirty_pages();
        int base_w;
        int base_c;
        int n;
        base_w = wr_q.size();
        base_c = clr_q.size();
        page_dirty = 8'b0000_0101;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wr_q.size() - base_w !== 264) begin
            n_bad++;
            $display("FAIL dirty_pulses: got %0d required 264", wr_q.size() - base_w);
        end
        if (wr_q.size() - base_w >= 264) begin
            n_cmp++;
            if (wr_q[base_w] !== {2'b01, 1'b0, 8'hB8} || wr_q[base_w + 66] !== {2'b10, 1'b0, 8'hB8} ||
                wr_q[base_w + 132] !== {2'b01, 1'b0, 8'hBA} || wr_q[base_w + 198] !== {2'b10, 1'b0, 8'hBA}) begin
                n_bad++;
                $display("FAIL dirty_pages: got %h %h %h %h required 0b8 4b8 0ba 4ba", wr_q[base_w],
                         wr_q[base_w + 66], wr_q[base_w + 132], wr_q[base_w + 198]);
            end
        end
        n_cmp++;
        if (clr_q.size() - base_c !== 2) begin
            n_bad++;
            $display("FAIL dirty_clr_count: got %0d required 2", clr_q.size() - base_c);
        end else begin
            n_cmp++;
            if (clr_q[base_c] !== 8'h01 || clr_q[base_c + 1] !== 8'h04) begin
                n_bad++;
                $display("FAIL dirty_clr_bits: got %h %h required 01 04", clr_q[base_c], clr_q[base_c + 1]);
            end
        end
        // Nothing dirty: frame_done two clocks after leaving IDLE.
        page_dirty = 8'h00;
        base_w = wr_q.size();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 2) begin
            n_bad++;
            $display("FAIL clean_frame_latency: got %0d clks required 2", n);
        end
        n_cmp++;
        if (wr_q.size() - base_w !== 0) begin
            n_bad++;
            $display("FAIL clean_frame_writes: got %0d required 0", wr_q.size() - base_w);
        end
        page_dirty = 8'hFF;
    endtask
`endif

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (!(fb_page === 3'd5 && lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (fb_page !== 3'd5 || lcd_e !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_reach_page5: fb_page=%0d e=%b required 5 1", fb_page, lcd_e);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({lcd_e, lcd_cs, lcd_reset_n, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: e=%b cs=%b reset_n=%b busy=%b required all 0",
                     lcd_e, lcd_cs, lcd_reset_n, busy);
        end
        repeat (3) @(negedge clk);
        test_power_up();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_full_frame();
        test_back_to_back();
`ifdef GLCD_DIRTY_PAGE_EN
        test_dirty_pages();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
